// File: rtl/mac_feed_ctrl_pkg.sv
// Shared definitions for the MAC input-feed sequencer: the controller state
// encoding and the 2-bit instruction codes sent down the input pipeline.
package mac_feed_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GAP,
      ST_EXEC,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] INST_IDLE = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_feed_ctrl_burst.sv
// Base+length SRAM address generator. A load pulse captures a new base and
// length and rewinds the index; each advance pulse steps to the next row.
// The index simply holds when not advanced, which is how a stall freezes the
// address. Addresses wrap modulo 2^addr_w.
module mac_feed_burst #(
   parameter int addr_w = 11,
   parameter int cnt_w  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [addr_w-1:0] base_i,
   input  logic [cnt_w-1:0]  len_i,
   input  logic              adv_i,
   output logic [addr_w-1:0] addr_o,
   output logic              last_o
);

   logic [addr_w-1:0] base_q, base_d;
   logic [cnt_w-1:0]  len_q, len_d;
   logic [cnt_w-1:0]  idx_q, idx_d;

   // A reload takes priority and restarts the burst at index 0; otherwise the
   // index only moves when the controller actually issues a read.
   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      idx_d  = idx_q;
      if (load_i) begin
         base_d = base_i;
         len_d  = len_i;
         idx_d  = '0;
      end else if (adv_i) begin
         idx_d = idx_q + cnt_w'(1);
      end
   end

   // Burst registers, cleared asynchronously so the address bus reads 0 in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end

   assign addr_o = base_q + addr_w'(idx_q);
   assign last_o = (idx_q == len_q - cnt_w'(1));

endmodule

// File: rtl/mac_feed_ctrl.sv
// Sequencer feeding the MAC array input pipeline from the activation/weight
// SRAM: kernel-load burst, column settle gap, execute burst, pipeline drain,
// then a one-cycle done pulse. Read enables are combinational from the current
// state and stall so a stalled cycle never issues; the instruction is
// registered so it lines up with the SRAM read data one cycle later.
module mac_feed_ctrl
   import mac_feed_ctrl_pkg::*;
#(
   parameter int col      = 8,
   parameter int pr       = 8,
   parameter int addr_w   = 11,
   parameter int cnt_w    = 11,
   parameter int pipe_lat = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] load_base,
   input  logic [cnt_w-1:0]  load_len,
   input  logic [addr_w-1:0] exec_base,
   input  logic [cnt_w-1:0]  exec_len,
   input  logic              stall,
   output logic              mem_cen,
   output logic [addr_w-1:0] mem_addr,
   output logic [1:0]        inst_out,
   output logic              busy,
   output logic              done
);

   // Degenerate sizes would make the gap/drain counters never terminate.
   if (col < 1 || pr < 1 || pipe_lat < 1) begin : g_param_check
      $error("mac_feed_ctrl: col, pr and pipe_lat must all be at least 1");
   end

   state_t            state_q, state_d;
   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic [addr_w-1:0] execBase_q, execBase_d;
   logic [cnt_w-1:0]  execLen_q, execLen_d;
   logic [1:0]        inst_q, inst_d;

   logic              burstLoad;
   logic [addr_w-1:0] burstBase;
   logic [cnt_w-1:0]  burstLen;
   logic              issue;
   logic [addr_w-1:0] burstAddr;
   logic              burstLast;

   // One generator serves both bursts: loaded with the kernel range when a
   // tile starts and reloaded with the activation range as the gap ends.
   mac_feed_burst #(
      .addr_w (addr_w),
      .cnt_w  (cnt_w)
   ) u_burst (
      .clk    (clk),
      .reset  (reset),
      .load_i (burstLoad),
      .base_i (burstBase),
      .len_i  (burstLen),
      .adv_i  (issue),
      .addr_o (burstAddr),
      .last_o (burstLast)
   );

   // Next-state logic. The execute range is captured at start so later changes
   // on the inputs cannot disturb a tile in flight. The gap counter only counts
   // unstalled cycles; the drain counter runs regardless of stall because the
   // reads it waits on were already issued.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      execBase_d = execBase_q;
      execLen_d  = execLen_q;
      inst_d     = INST_IDLE;
      burstLoad  = 1'b0;
      burstBase  = load_base;
      burstLen   = load_len;
      issue      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               execBase_d = exec_base;
               execLen_d  = exec_len;
               burstLoad  = 1'b1;
               cnt_d      = '0;
               state_d    = (load_len == '0) ? ST_GAP : ST_LOAD;
            end
         end
         ST_LOAD: begin
            issue = !stall;
            if (issue) begin
               inst_d = INST_LOAD;
               if (burstLast) begin
                  cnt_d   = '0;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (!stall) begin
               if (cnt_q == cnt_w'(col - 1)) begin
                  cnt_d     = '0;
                  burstLoad = 1'b1;
                  burstBase = execBase_q;
                  burstLen  = execLen_q;
                  state_d   = (execLen_q == '0) ? ST_DRAIN : ST_EXEC;
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         ST_EXEC: begin
            issue = !stall;
            if (issue) begin
               inst_d = INST_EXEC;
               if (burstLast) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == cnt_w'(pipe_lat - 1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state registers; async reset returns to an idle, quiet bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         execBase_q <= '0;
         execLen_q  <= '0;
         inst_q     <= INST_IDLE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         execBase_q <= execBase_d;
         execLen_q  <= execLen_d;
         inst_q     <= inst_d;
      end
   end

   assign mem_cen  = !issue;
   assign mem_addr = burstAddr;
   assign inst_out = inst_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Directed bench for mac_feed_ctrl. Each tile is launched with applyStimulus,
// which records per-cycle outputs indexed by cycles after the start edge; the
// expectations below are worked out by hand from the tile lengths.
module tb_mac_feed_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stall;
   logic [10:0] load_base;
   logic [10:0] load_len;
   logic [10:0] exec_base;
   logic [10:0] exec_len;
   logic        mem_cen;
   logic [10:0] mem_addr;
   logic [1:0]  inst_out;
   logic        busy;
   logic        done;

   int testsRun = 0;
   int testsFailed = 0;

   logic        cenArr [0:255];
   logic [10:0] addrArr[0:255];
   logic [1:0]  instArr[0:255];
   logic        busyArr[0:255];
   logic [10:0] obsAddr[$];
   logic [10:0] expAddr[$];
   int          doneCycle;
   int          doneCount;

   mac_feed_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .load_base (load_base),
      .load_len  (load_len),
      .exec_base (exec_base),
      .exec_len  (exec_len),
      .stall     (stall),
      .mem_cen   (mem_cen),
      .mem_addr  (mem_addr),
      .inst_out  (inst_out),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   // Cycle n is the n-th clock period after the edge that samples start.
   // After cycle 0 the tile inputs are driven to unrelated values, and start
   // is optionally re-pulsed, to show the controller ignores them mid-tile.
   task automatic applyStimulus(input logic [10:0] lb, input logic [10:0] ll,
                                input logic [10:0] eb, input logic [10:0] el,
                                input int stallFrom, input int stallTo,
                                input int restartAt, input int maxCycles);
      obsAddr.delete();
      doneCycle = -1;
      doneCount = 0;
      for (int n = 0; n <= maxCycles; n++) begin
         @(negedge clk);
         if (n == 0) begin
            load_base = lb;
            load_len  = ll;
            exec_base = eb;
            exec_len  = el;
         end else begin
            load_base = 11'h5A5;
            load_len  = 11'd1;
            exec_base = 11'h2C3;
            exec_len  = 11'd1;
         end
         start = (n == 0) || (n == restartAt);
         stall = (n >= stallFrom) && (n <= stallTo);
         #1;
         cenArr[n]  = mem_cen;
         addrArr[n] = mem_addr;
         instArr[n] = inst_out;
         busyArr[n] = busy;
         if (mem_cen === 1'b0) obsAddr.push_back(mem_addr);
         if (done === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = n;
         end
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   task automatic buildExp(input logic [10:0] lb, input logic [10:0] ll,
                           input logic [10:0] eb, input logic [10:0] el);
      expAddr.delete();
      for (int i = 0; i < int'(ll); i++) expAddr.push_back(lb + 11'(i));
      for (int i = 0; i < int'(el); i++) expAddr.push_back(eb + 11'(i));
   endtask

   task automatic checkAddrs(input string tag);
      checkOutput({tag, " read count"}, obsAddr.size(), expAddr.size());
      for (int i = 0; i < expAddr.size() && i < obsAddr.size(); i++)
         checkOutput($sformatf("%s addr[%0d]", tag, i), obsAddr[i], expAddr[i]);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      load_base = '0; load_len = '0; exec_base = '0; exec_len = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset mem_cen", mem_cen, 1'b1);
      checkOutput("reset mem_addr", mem_addr, 11'h000);
      checkOutput("reset inst_out", inst_out, 2'b00);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Basic tile: load 0x000..0x007, gap 9..16, exec 0x100..0x10F at 17..32.
      applyStimulus(11'h000, 11'd8, 11'h100, 11'd16, -1, -2, -1, 40);
      buildExp(11'h000, 11'd8, 11'h100, 11'd16);
      checkAddrs("A");
      checkOutput("A done cycle", doneCycle, 36);
      checkOutput("A done count", doneCount, 1);
      checkOutput("A busy c1", busyArr[1], 1'b1);
      checkOutput("A busy c36", busyArr[36], 1'b1);
      checkOutput("A busy c37", busyArr[37], 1'b0);
      checkOutput("A mem_cen c0", cenArr[0], 1'b1);
      checkOutput("A inst c1", instArr[1], 2'b00);
      checkOutput("A inst c2", instArr[2], 2'b01);
      checkOutput("A inst c9", instArr[9], 2'b01);
      checkOutput("A inst c10", instArr[10], 2'b00);
      checkOutput("A inst c17", instArr[17], 2'b00);
      checkOutput("A inst c18", instArr[18], 2'b10);
      checkOutput("A inst c33", instArr[33], 2'b10);
      checkOutput("A inst c34", instArr[34], 2'b00);

      // Same tile with stall over cycles 20..22 in the middle of EXEC.
      applyStimulus(11'h000, 11'd8, 11'h100, 11'd16, 20, 22, -1, 44);
      checkAddrs("B");
      checkOutput("B done cycle", doneCycle, 39);
      checkOutput("B mem_cen c21", cenArr[21], 1'b1);
      checkOutput("B addr hold c20", addrArr[20], 11'h103);
      checkOutput("B addr hold c22", addrArr[22], 11'h103);
      checkOutput("B inst c20", instArr[20], 2'b10);
      checkOutput("B inst c21", instArr[21], 2'b00);
      checkOutput("B inst c23", instArr[23], 2'b00);
      checkOutput("B inst c24", instArr[24], 2'b10);
      checkOutput("B inst c36", instArr[36], 2'b10);
      checkOutput("B inst c37", instArr[37], 2'b00);

      // No kernel rows: gap 1..8, exec 0x200..0x203 at 9..12.
      applyStimulus(11'h040, 11'd0, 11'h200, 11'd4, -1, -2, -1, 20);
      buildExp(11'h040, 11'd0, 11'h200, 11'd4);
      checkAddrs("C");
      checkOutput("C done cycle", doneCycle, 16);
      checkOutput("C mem_cen c8", cenArr[8], 1'b1);
      checkOutput("C mem_cen c9", cenArr[9], 1'b0);
      checkOutput("C inst c9", instArr[9], 2'b00);
      checkOutput("C inst c10", instArr[10], 2'b10);

      // Both lengths zero: no reads at all, done after gap and drain.
      applyStimulus(11'h040, 11'd0, 11'h200, 11'd0, -1, -2, -1, 18);
      checkOutput("D read count", obsAddr.size(), 0);
      checkOutput("D done cycle", doneCycle, 12);
      checkOutput("D done count", doneCount, 1);
      checkOutput("D busy c12", busyArr[12], 1'b1);
      checkOutput("D busy c13", busyArr[13], 1'b0);

      // Stall high with start and for cycles 1..2, exec range wrapping past 0x7FF.
      applyStimulus(11'h010, 11'd2, 11'h7FE, 11'd4, 0, 2, -1, 24);
      expAddr.delete();
      expAddr.push_back(11'h010);
      expAddr.push_back(11'h011);
      expAddr.push_back(11'h7FE);
      expAddr.push_back(11'h7FF);
      expAddr.push_back(11'h000);
      expAddr.push_back(11'h001);
      checkAddrs("E");
      checkOutput("E done cycle", doneCycle, 20);
      checkOutput("E busy c1", busyArr[1], 1'b1);
      checkOutput("E mem_cen c2", cenArr[2], 1'b1);
      checkOutput("E mem_cen c3", cenArr[3], 1'b0);
      checkOutput("E inst c3", instArr[3], 2'b00);
      checkOutput("E inst c4", instArr[4], 2'b01);

      // Start re-pulsed during the gap must be ignored.
      applyStimulus(11'h020, 11'd4, 11'h040, 11'd4, -1, -2, 5, 35);
      buildExp(11'h020, 11'd4, 11'h040, 11'd4);
      checkAddrs("F");
      checkOutput("F done cycle", doneCycle, 20);
      checkOutput("F done count", doneCount, 1);
      checkOutput("F busy c25", busyArr[25], 1'b0);

      // Asynchronous reset in the middle of LOAD, away from any clock edge.
      @(negedge clk);
      load_base = 11'h050; load_len = 11'd8; exec_base = 11'h060; exec_len = 11'd4;
      start = 1'b1; stall = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("G pre-reset mem_cen", mem_cen, 1'b0);
      checkOutput("G pre-reset mem_addr", mem_addr, 11'h052);
      checkOutput("G pre-reset inst", inst_out, 2'b01);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("G async mem_cen", mem_cen, 1'b1);
      checkOutput("G async mem_addr", mem_addr, 11'h000);
      checkOutput("G async inst", inst_out, 2'b00);
      checkOutput("G async busy", busy, 1'b0);
      checkOutput("G async done", done, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(11'h050, 11'd2, 11'h060, 11'd2, -1, -2, -1, 20);
      buildExp(11'h050, 11'd2, 11'h060, 11'd2);
      checkAddrs("G");
      checkOutput("G done cycle", doneCycle, 16);
      checkOutput("G done count", doneCount, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
